fp_regfile_dump: RTL

FP_REGFILE_DUMP -- requirements
Module: fp_regfile_dump

---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_dump_fifo.sv | 59 +++++
 rtl/fp_regfile_dump.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants and FSM state encoding for the FP register-file dump engine.
package fp_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 6;
    localparam int NUM_REGS   = 32;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fp_dump_fifo.sv
// In-order FIFO with two write ports and one read port.
//   Clk, Rst     : clock, synchronous active-high reset
//   flush        : discard all contents (has priority over push/pop)
//   wr_en0/1     : push wr_data0 then wr_data1 (wr_en1 only together with wr_en0)
//   rd_en        : pop the head when non-empty
//   head         : current head entry (undefined when count == 0)
//   count        : number of stored entries
// DEPTH must be a power of two; the writer guarantees free space.
module fp_dump_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       flush,
    input  logic                       wr_en0,
    input  logic [WIDTH-1:0]           wr_data0,
    input  logic                       wr_en1,
    input  logic [WIDTH-1:0]           wr_data1,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    wr_ptr1;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    push_n;
    logic             pop;

    assign wr_ptr1 = wr_ptr + 1'b1;
    assign push_n  = CW'(wr_en0) + CW'(wr_en1);
    assign pop     = rd_en && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (!Rst && !flush) begin
            if (wr_en0) mem[wr_ptr]  <= wr_data0;
            if (wr_en1) mem[wr_ptr1] <= wr_data1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + push_n - CW'(pop);
        end
    end

endmodule

// File: rtl/fp_regfile_dump.sv
// Streams a range of FP registers out through a valid/ready handshake.
//   Clk, Rst                 : clock, synchronous active-high reset
//   start, first_addr,
//   last_addr                : dump request with inclusive range (sampled in IDLE)
//   abort                    : cancel an active dump, flushing queued words
//   rf_addr_A/B, rf_data_A/B : two combinational register-file read ports
//   dout_data/addr/valid,
//   dout_ready               : output stream, one register per beat
//   busy                     : dump in progress (READ or DRAIN)
//   done, err                : single-cycle completion / bad-range pulses
module fp_regfile_dump #(
    parameter int DATA_WIDTH = fp_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fp_pkg::ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_addr_A,
    output logic [ADDR_WIDTH-1:0] rf_addr_B,
    input  logic [DATA_WIDTH-1:0] rf_data_A,
    input  logic [DATA_WIDTH-1:0] rf_data_B,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic [ADDR_WIDTH-1:0] dout_addr,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    import fp_pkg::*;

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d, last_q, last_d, cur_p1;
    logic                  done_q, done_d, err_q, err_d;
    logic                  push0, push1, flush;
    logic [EW-1:0]         head;
    logic [CW-1:0]         fifo_count;

    assign cur_p1 = cur_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        push0     = 1'b0;
        push1     = 1'b0;
        flush     = 1'b0;
        rf_addr_A = '0;
        rf_addr_B = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (first_addr <= last_addr && last_addr <= MAX_ADDR) begin
                        cur_d   = first_addr;
                        last_d  = last_addr;
                        state_d = ST_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                rf_addr_A = cur_q;
                rf_addr_B = cur_p1;
                // Free space is judged on the pre-pop count so a same-cycle pop is never relied upon.
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cur_q < last_q && fifo_count <= CW'(FIFO_DEPTH - 2)) begin
                    push0 = 1'b1;
                    push1 = 1'b1;
                    cur_d = cur_q + 2'd2;
                    if (cur_p1 == last_q) state_d = ST_DRAIN;
                end else if (cur_q == last_q && fifo_count <= CW'(FIFO_DEPTH - 1)) begin
                    push0   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (fifo_count == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    fp_dump_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .flush    (flush),
        .wr_en0   (push0),
        .wr_data0 ({cur_q, rf_data_A}),
        .wr_en1   (push1),
        .wr_data1 ({cur_p1, rf_data_B}),
        .rd_en    (dout_ready),
        .head     (head),
        .count    (fifo_count)
    );

    // Head is gated so the stream reads as zero whenever nothing is queued.
    assign dout_valid = (fifo_count != '0);
    assign dout_data  = dout_valid ? head[DATA_WIDTH-1:0] : '0;
    assign dout_addr  = dout_valid ? head[DATA_WIDTH +: ADDR_WIDTH] : '0;
    assign busy       = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done       = done_q;
    assign err        = err_q;

endmodule
